// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the PIPE execute stage: instruction/function codes,
// register ids, condition-code layout and the branch/cmov condition evaluator.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] IIADDQ  = 4'hC;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3
  } alu_fn_e;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'h0,
    C_LE     = 4'h1,
    C_L      = 4'h2,
    C_E      = 4'h3,
    C_NE     = 4'h4,
    C_GE     = 4'h5,
    C_G      = 4'h6
  } cond_e;

  // cc is packed as {ZF,SF,OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET = 3'b100;

  function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf;
    logic lt;
    zf = cc[CC_ZF];
    lt = cc[CC_SF] ^ cc[CC_OF];
    case (ifun)
      C_ALWAYS: cond_eval = 1'b1;
      C_LE:     cond_eval = lt | zf;
      C_L:      cond_eval = lt;
      C_E:      cond_eval = zf;
      C_NE:     cond_eval = ~zf;
      C_GE:     cond_eval = ~lt;
      C_G:      cond_eval = ~lt & ~zf;
      default:  cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu_flags.sv
// Combinational execute ALU: selects the valE computation for each icode and
// produces the {ZF,SF,OF} flags that the CC register may capture.
module y86_alu_flags
  import y86_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int STACK_STEP = 8
) (
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [DATA_W-1:0] val_a,
  input  logic [DATA_W-1:0] val_b,
  input  logic [DATA_W-1:0] val_c,
  output logic [DATA_W-1:0] val_e,
  output logic [2:0]        flags
);

  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);

  logic of_flag;

  // Overflow is only meaningful for add/sub style ops; logic ops clear it
  always_comb begin
    val_e   = '0;
    of_flag = 1'b0;
    case (icode)
      IRRMOVQ:          val_e = val_a;
      IIRMOVQ:          val_e = val_c;
      IRMMOVQ, IMRMOVQ: val_e = val_b + val_c;
      IOPQ: begin
        case (ifun)
          ALU_ADD: begin
            val_e   = val_b + val_a;
            of_flag = (val_a[MSB] == val_b[MSB]) && (val_e[MSB] != val_a[MSB]);
          end
          ALU_SUB: begin
            val_e   = val_b - val_a;
            of_flag = (val_a[MSB] != val_b[MSB]) && (val_e[MSB] != val_b[MSB]);
          end
          ALU_AND: val_e = val_b & val_a;
          ALU_XOR: val_e = val_b ^ val_a;
          default: val_e = '0;
        endcase
      end
      IIADDQ: begin
        val_e   = val_b + val_c;
        of_flag = (val_c[MSB] == val_b[MSB]) && (val_e[MSB] != val_c[MSB]);
      end
      ICALL, IPUSHQ: val_e = val_b - STEP;
      IRET, IPOPQ:   val_e = val_b + STEP;
      default:       val_e = '0;
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[CC_ZF] = (val_e == '0);
    flags[CC_SF] = val_e[MSB];
    flags[CC_OF] = of_flag;
  end

endmodule

// File: rtl/y86_execute_pipe.sv
// Y86 PIPE execute stage: ALU, condition evaluation, gated CC register, decode
// forwarding taps and the E->M pipeline register with stall/bubble control.
module y86_execute_pipe
  import y86_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int STACK_STEP = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_valid,
  input  logic [3:0]        e_icode,
  input  logic [3:0]        e_ifun,
  input  logic [DATA_W-1:0] e_valA,
  input  logic [DATA_W-1:0] e_valB,
  input  logic [DATA_W-1:0] e_valC,
  input  logic [3:0]        e_dstE,
  input  logic [3:0]        e_dstM,
  input  logic              cc_block,
  input  logic              stall_m,
  input  logic              bubble_m,
  output logic [DATA_W-1:0] fwd_valE,
  output logic [3:0]        fwd_dstE,
  output logic              m_valid,
  output logic [3:0]        m_icode,
  output logic              m_cnd,
  output logic [DATA_W-1:0] m_valE,
  output logic [DATA_W-1:0] m_valA,
  output logic [3:0]        m_dstE,
  output logic [3:0]        m_dstM,
  output logic [2:0]        cc
);

  logic [DATA_W-1:0] val_e;
  logic [2:0]        alu_flags;
  logic              cnd;
  logic              cc_we;

  y86_alu_flags #(
    .DATA_W    (DATA_W),
    .STACK_STEP(STACK_STEP)
  ) u_alu (
    .icode(e_icode),
    .ifun (e_ifun),
    .val_a(e_valA),
    .val_b(e_valB),
    .val_c(e_valC),
    .val_e(val_e),
    .flags(alu_flags)
  );

  // Conditions read the registered cc, so a flag-setting op is seen one cycle later
  always_comb begin
    cnd = 1'b0;
    if (e_icode == IJXX || e_icode == IRRMOVQ) cnd = cond_eval(cc, e_ifun);
  end

  always_comb begin
    fwd_valE = val_e;
    fwd_dstE = e_dstE;
    if (!e_valid || (e_icode == IRRMOVQ && !cnd)) fwd_dstE = RNONE;
  end

  assign cc_we = e_valid && !cc_block && !stall_m &&
                 ((e_icode == IOPQ && e_ifun <= ALU_XOR) || e_icode == IIADDQ);

  always_ff @(posedge clk) begin
    if (reset)      cc <= CC_RESET;
    else if (cc_we) cc <= alu_flags;
  end

  // A stalled M register freezes even if a bubble is also requested
  always_ff @(posedge clk) begin
    if (reset || (!stall_m && (bubble_m || !e_valid))) begin
      m_valid <= 1'b0;
      m_icode <= INOP;
      m_cnd   <= 1'b0;
      m_valE  <= '0;
      m_valA  <= '0;
      m_dstE  <= RNONE;
      m_dstM  <= RNONE;
    end else if (!stall_m) begin
      m_valid <= 1'b1;
      m_icode <= e_icode;
      m_cnd   <= cnd;
      m_valE  <= val_e;
      m_valA  <= e_valA;
      m_dstE  <= fwd_dstE;
      m_dstM  <= e_dstM;
    end
  end

endmodule

// File: doc/y86_execute_pipe.md
Name: y86_execute_pipe

Overview:
- Parametrised, pipelined Y86 execute stage for the PIPE processor, placed between the decode/E register and the memory stage.
- Computes valE and cnd.
- Holds the condition-code register as architectural state with gated update.
- Drives the E→M pipeline register with stall and bubble control.
- Adds iaddq, a width parameter, a configurable stack step, and combinational forwarding outputs for decode.

Parameters:
- DATA_W, 64, datapath width of valA/valB/valC/valE.
- STACK_STEP, 8, byte delta applied to the stack pointer by call/ret/pushq/popq.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- e_valid  in  1  E-stage holds a real instruction.
- e_icode  in  4  instruction code.
- e_ifun  in  4  function code.
- e_valA  in  DATA_W  operand A.
- e_valB  in  DATA_W  operand B.
- e_valC  in  DATA_W  constant.
- e_dstE  in  4  destination register for valE.
- e_dstM  in  4  destination register for valM.
- cc_block  in  1  suppresses CC update; driven by an exception in M/W.
- stall_m  in  1  hold the M register.
- bubble_m  in  1  load a NOP into the M register.
- fwd_valE  out  DATA_W  combinational valE for forwarding.
- fwd_dstE  out  4  combinational effective dstE; RNONE when a cmov is not taken.
- m_valid  out  1  M register: valid.
- m_icode  out  4  M register: instruction code.
- m_cnd  out  1  M register: condition result.
- m_valE  out  DATA_W  M register: valE.
- m_valA  out  DATA_W  M register: valA.
- m_dstE  out  4  M register: dstE.
- m_dstM  out  4  M register: dstM.
- cc  out  3  {ZF,SF,OF} condition-code register.

Behaviour:
- Reset values, applied at the posedge of clk while reset=1:
  - m_valid=0, m_icode=INOP(4'h1), m_cnd=0, m_valE=0, m_valA=0, m_dstE=m_dstM=RNONE(4'hF).
  - cc=3'b100 (ZF=1, SF=0, OF=0).
  - reset overrides stall_m and bubble_m.
- valE by instruction (combinational, all arithmetic modulo 2^DATA_W):
  - cmovXX: valE=valA.
  - irmovq: valE=valC.
  - rmmovq, mrmovq: valE=valB+valC.
  - OPq ifun 0..3: valB+valA, valB−valA, valB&valA, valB^valA.
  - OPq ifun>3: valE=0, no CC update.
  - iaddq (4'hC): valE=valB+valC.
  - call, pushq: valE=valB−STACK_STEP.
  - ret, popq: valE=valB+STACK_STEP.
  - all other icodes: valE=0.
- cnd (combinational) is evaluated from the registered cc, i.e. the value before this cycle's update.
  - Applies to jXX and cmovXX, ifun 0..6 = always, le, l, e, ne, ge, g, with standard Y86 equations.
  - ifun>6 gives cnd=0.
  - Other icodes give cnd=0.
- Flags:
  - ZF = (valE==0).
  - SF = valE[DATA_W-1].
  - OF for add and iaddq: operands share a sign and the result sign differs.
  - OF for sub: valB and valA have different signs and the result sign differs from valB.
  - OF=0 for and and xor.
- CC update at posedge when all of the following hold: e_valid, icode∈{OPq (ifun≤3), iaddq}, !cc_block, !stall_m, !reset. Otherwise cc holds.
- Forwarding outputs:
  - fwd_valE equals the computed valE.
  - fwd_dstE = (icode==cmovXX && !cnd) ? RNONE : e_dstE.
  - When e_valid=0, fwd_dstE=RNONE.
- M register, priority reset > stall_m > bubble_m > load:
  - stall_m=1: all m_* hold. If bubble_m is also asserted, stall wins.
  - bubble_m=1: load the reset values. cc is unaffected except through the update rule above.
  - Otherwise load the E-stage values, with m_dstE=fwd_dstE and m_valid=e_valid.
  - e_valid=0 loads bubble values.
- Latency: one cycle from E inputs to m_* outputs; zero cycles to fwd_*.
- Same-cycle back-to-back: an OPq followed by jXX sees the OPq's flags on the next cycle. The jXX in the same cycle as the update sees the old cc.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants IHALT..IPOPQ and IIADDQ.
  - ifun constants for ALU ops and conditions.
  - RNONE.
  - CC bit indices.
- One sub-module, y86_alu_flags: parametrised DATA_W, purely combinational ALU plus ZF/SF/OF generation. The CC register and M register stay in y86_execute_pipe.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then e_valid=0 → cc=3'b100, m_icode=4'h1, m_dstE=4'hF, m_valid=0.
- subq overflow: valB=64'h8000_0000_0000_0000, valA=1, ifun=1 → next cycle m_valE=64'h7FFF_FFFF_FFFF_FFFF, cc={0,0,1}. A following jl (ifun 2) gives m_cnd=1.
- cc_block: addq valA=5, valB=−5 with cc_block=1 → m_valE=0, cc remains 3'b100 from reset. Repeat with cc_block=0 → cc=3'b100 set by the op. Then addq 1+1 → cc=3'b000.
- cmovne not taken: cc ZF=1, icode=2, ifun=4, e_dstE=3 → fwd_dstE=4'hF, m_dstE=4'hF, m_cnd=0.
- stall/bubble priority: load pushq valB=64'h100 (m_valE=64'hF8). Assert stall_m and bubble_m together for 2 cycles → m_* hold. bubble_m alone → NOP loaded.
- DATA_W=32, STACK_STEP=4: popq valB=32'hFFFF_FFFE → m_valE=32'h0000_0002 (wrap). iaddq valB=7, valC=−7 → ZF=1.
